// File: rtl/fp_div_round_pkg.sv
// Shared fp64 back-end definitions: FSM states, binary64 constants,
// rounding-mode encodings and exception flag bit positions.
package fp_div_round_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [63:0] FP64_QNAN    = 64'h7FF8_0000_0000_0000;
  localparam int          FP64_EXP_MAX = 2047;
  localparam int          FP64_BIAS    = 1023;

  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RTZ = 2'd1;
  localparam logic [1:0] RM_RUP = 2'd2;
  localparam logic [1:0] RM_RDN = 2'd3;

  // flags_out = {overflow, underflow, inexact, div_by_zero}
  localparam int FLAG_OVF = 3;
  localparam int FLAG_UNF = 2;
  localparam int FLAG_INX = 1;
  localparam int FLAG_DBZ = 0;

endpackage

// File: rtl/fp_round_inc.sv
// Round-increment decision from guard/round/sticky, result lsb and sign.
// Shared by the fp64 add/mul/div back-ends.
module fp_round_inc
  import fp_div_round_pkg::*;
(
  input  logic       g,
  input  logic       r,
  input  logic       s,
  input  logic       lsb,
  input  logic       sign,
  input  logic [1:0] rm,
  output logic       inc
);

  always_comb begin
    inc = 1'b0;
    case (rm)
      RM_RNE:  inc = g & (r | s | lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = (g | r | s) & ~sign;
      RM_RDN:  inc = (g | r | s) & sign;
      default: inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/fp_div_round.sv
// FP64 divide back-end: normalise, round, pack the divider quotient.
// Define FP_DIV_RMODES_EN to honour rm_in; otherwise round-to-nearest-even only.
module fp_div_round
  import fp_div_round_pkg::*;
#(
  parameter int EXP_W = 13,
  parameter int Q_W   = 56,
  parameter int R_W   = 53
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [Q_W-1:0]   quotient_in,
  input  logic [R_W-1:0]   remainder_in,
  input  logic             sign_in,
  input  logic [EXP_W-1:0] exp_in,
  input  logic             nan_in,
  input  logic             inf_in,
  input  logic             zero_in,
  input  logic             dbz_in,
  input  logic [1:0]       rm_in,
  output logic [63:0]      result_out,
  output logic [3:0]       flags_out,
  output logic             ready,
  output logic             busy
);

  localparam logic signed [EXP_W-1:0] E_MAX  = EXP_W'(FP64_EXP_MAX);
  localparam logic signed [EXP_W-1:0] E_ZERO = '0;

  state_t                  st;
  logic [Q_W-1:0]          q_r;
  logic                    rnz_r, sign_r, nan_r, inf_r, zero_r, dbz_r;
  logic signed [EXP_W-1:0] exp_r;

  logic [51:0]             frac_n;
  logic                    g_n, r_n, s_n;
  logic signed [EXP_W-1:0] e_n;

  logic [1:0]              rm_eff;
  logic                    inc, ovf_to_max, inexact;
  logic [52:0]             fsum;
  logic signed [EXP_W-1:0] e_rnd;
  logic [63:0]             res_c;
  logic [3:0]              flg_c;

`ifdef FP_DIV_RMODES_EN
  logic [1:0] rm_r;
  assign rm_eff     = rm_r;
  // Directed rounding toward zero for this sign saturates instead of overflowing to inf.
  assign ovf_to_max = (rm_r == RM_RTZ) | ((rm_r == RM_RUP) & sign_r) |
                      ((rm_r == RM_RDN) & ~sign_r);
`else
  logic unused_rm;
  assign unused_rm  = ^rm_in;
  assign rm_eff     = RM_RNE;
  assign ovf_to_max = 1'b0;
`endif

  fp_round_inc u_inc (
    .g    (g_n),
    .r    (r_n),
    .s    (s_n),
    .lsb  (frac_n[0]),
    .sign (sign_r),
    .rm   (rm_eff),
    .inc  (inc)
  );

  always_comb begin
    // Carry out of the fraction add leaves frac=0, exactly the renormalised mantissa.
    fsum    = {1'b0, frac_n} + {52'b0, inc};
    e_rnd   = e_n + EXP_W'(fsum[52]);
    inexact = g_n | r_n | s_n;
    res_c   = {sign_r, e_rnd[10:0], fsum[51:0]};
    flg_c   = '0;
    flg_c[FLAG_DBZ] = dbz_r;
    if (nan_r) begin
      res_c = FP64_QNAN;
    end else if (inf_r) begin
      res_c = {sign_r, 11'h7FF, 52'b0};
    end else if (zero_r) begin
      res_c = {sign_r, 63'b0};
    end else if (e_rnd >= E_MAX) begin
      res_c = ovf_to_max ? {sign_r, 11'h7FE, {52{1'b1}}} : {sign_r, 11'h7FF, 52'b0};
      flg_c[FLAG_OVF] = 1'b1;
      flg_c[FLAG_INX] = 1'b1;
    end else if (e_rnd <= E_ZERO) begin
      res_c = {sign_r, 63'b0};
      flg_c[FLAG_UNF] = 1'b1;
      flg_c[FLAG_INX] = 1'b1;
    end else begin
      flg_c[FLAG_INX] = inexact;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= S_IDLE;
      q_r        <= '0;
      rnz_r      <= 1'b0;
      sign_r     <= 1'b0;
      exp_r      <= '0;
      nan_r      <= 1'b0;
      inf_r      <= 1'b0;
      zero_r     <= 1'b0;
      dbz_r      <= 1'b0;
`ifdef FP_DIV_RMODES_EN
      rm_r       <= RM_RNE;
`endif
      frac_n     <= '0;
      g_n        <= 1'b0;
      r_n        <= 1'b0;
      s_n        <= 1'b0;
      e_n        <= '0;
      result_out <= '0;
      flags_out  <= '0;
      ready      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (st)
        S_IDLE: if (start) begin
          q_r    <= quotient_in;
          rnz_r  <= |remainder_in;
          sign_r <= sign_in;
          exp_r  <= exp_in;
          nan_r  <= nan_in;
          inf_r  <= inf_in;
          zero_r <= zero_in;
          dbz_r  <= dbz_in;
`ifdef FP_DIV_RMODES_EN
          rm_r   <= rm_in;
`endif
          busy   <= 1'b1;
          st     <= S_NORM;
        end
        S_NORM: begin
          if (q_r[55]) begin
            frac_n <= q_r[54:3];
            g_n    <= q_r[2];
            r_n    <= q_r[1];
            s_n    <= q_r[0] | rnz_r;
            e_n    <= exp_r;
          end else begin
            frac_n <= q_r[53:2];
            g_n    <= q_r[1];
            r_n    <= q_r[0];
            s_n    <= rnz_r;
            e_n    <= exp_r - EXP_W'(1);
          end
          st <= S_ROUND;
        end
        S_ROUND: begin
          result_out <= res_c;
          flags_out  <= flg_c;
          ready      <= 1'b1;
          st         <= S_DONE;
        end
        S_DONE: begin
          busy <= 1'b0;
          st   <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule
